// File: rtl/morse_pkg.sv
// Shared definitions for the Morse character encoder.
//   state_t  : encoder FSM states
//   units_t  : duration expressed in Morse time units
//   *_UNITS  : standard Morse element lengths in units
package morse_pkg;

  typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

  localparam int UNITS_W = 3;
  typedef logic [UNITS_W-1:0] units_t;

  localparam units_t DOT_UNITS      = 3'd1;
  localparam units_t DASH_UNITS     = 3'd3;
  localparam units_t SYM_GAP_UNITS  = 3'd1;
  localparam units_t CHAR_GAP_UNITS = 3'd3;
  localparam units_t WORD_GAP_UNITS = 3'd7;

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter measuring element durations in Morse units.
//   clk, reset : clock, synchronous active-high reset
//   load       : reload with units*UNIT_CYCLES-1 (state entry)
//   units      : duration in Morse units for the next element
//   last       : high while the count is 0, i.e. final cycle of the element
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter  int UNIT_CYCLES = 4,
  localparam int CNT_W       = $clog2(7*UNIT_CYCLES+1)
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  units_t units,
  output logic   last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(int'(units) * UNIT_CYCLES - 1);
    end else if (count != '0) begin
      // Saturates at 0 so an idle timer keeps reporting last.
      count <= count - CNT_W'(1);
    end
  end

  assign last = (count == '0);

endmodule

// File: rtl/morse_char_encoder.sv
// Whole-character Morse keyer: accepts a packed dot/dash pattern per
// valid/ready handshake and emits on/off keying with symbol, character
// and word spacing.
//   clk, reset  : clock, synchronous active-high reset
//   in_valid    : character present on in_code/in_len/in_word_gap
//   in_ready    : character can be accepted this cycle
//   in_code     : symbol bits, bit 0 first, 1=dash 0=dot
//   in_len      : symbols to send, clamped to MAX_LEN
//   in_word_gap : trailing gap is a word gap (7 units) instead of 3 units
//   z           : keying output, 1=mark
//   busy        : character in progress
//   done        : pulse on the final cycle of the trailing gap
module morse_char_encoder
  import morse_pkg::*;
#(
  parameter  int MAX_LEN     = 5,
  parameter  int UNIT_CYCLES = 4,
  localparam int LEN_W       = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [MAX_LEN-1:0] in_code,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               in_word_gap,
  output logic               z,
  output logic               busy,
  output logic               done
);

  state_t             state, next_state;
  logic [MAX_LEN-1:0] code, code_shift;
  logic [LEN_W-1:0]   remaining, len_clamped;
  logic               word_gap;
  logic               accept, advance, load, last;
  units_t             units;

  assign code_shift  = code >> 1;
  assign len_clamped = (in_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : in_len;
  assign in_ready    = (state == IDLE) && !reset;
  assign accept      = in_valid && in_ready;

  morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .units (units),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    units      = DOT_UNITS;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (len_clamped != '0) begin
            next_state = MARK;
            units      = in_code[0] ? DASH_UNITS : DOT_UNITS;
          end else begin
            next_state = GAP;
            units      = in_word_gap ? WORD_GAP_UNITS : CHAR_GAP_UNITS;
          end
        end
      end
      MARK: begin
        if (last) begin
          load = 1'b1;
          // remaining still counts the symbol just sent
          if (remaining > LEN_W'(1)) begin
            next_state = SPACE;
            units      = SYM_GAP_UNITS;
          end else begin
            next_state = GAP;
            units      = word_gap ? WORD_GAP_UNITS : CHAR_GAP_UNITS;
          end
        end
      end
      SPACE: begin
        if (last) begin
          load       = 1'b1;
          advance    = 1'b1;
          next_state = MARK;
          units      = code_shift[0] ? DASH_UNITS : DOT_UNITS;
        end
      end
      GAP: begin
        if (last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code      <= '0;
      remaining <= '0;
      word_gap  <= 1'b0;
    end else if (accept) begin
      code      <= in_code;
      remaining <= len_clamped;
      word_gap  <= in_word_gap;
    end else if (advance) begin
      code      <= code_shift;
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign z    = (state == MARK);
  assign busy = (state != IDLE);
  assign done = (state == GAP) && last;

endmodule

// File: tb/tb_morse_char_encoder.sv
module tb_morse_char_encoder;

  localparam int U = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_code;
  logic [2:0] in_len;
  logic       in_word_gap;
  logic       z, busy, done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Each entry is one expected output cycle: {z, done}.
  logic [1:0] mq[$];

  morse_char_encoder #(.MAX_LEN(5), .UNIT_CYCLES(U)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .in_len      (in_len),
    .in_word_gap (in_word_gap),
    .z           (z),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic push_char(input logic [4:0] c, input int l, input logic wg);
    int n;
    int g;
    n = (l > 5) ? 5 : l;
    for (int i = 0; i < n; i++) begin
      repeat ((c[i] ? 3 : 1) * U) mq.push_back(2'b10);
      if (i < n - 1) repeat (U) mq.push_back(2'b00);
    end
    g = (wg ? 7 : 3) * U;
    repeat (g - 1) mq.push_back(2'b00);
    mq.push_back(2'b01);
  endtask

  always @(posedge clk) begin
    if (reset) mq.delete();
    else if (mq.size() == 0) begin
      if (in_valid) push_char(in_code, int'(in_len), in_word_gap);
    end else begin
      void'(mq.pop_front());
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    logic ez, ed, eb, er;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        eb = (mq.size() != 0);
        ez = eb ? mq[0][1] : 1'b0;
        ed = eb ? mq[0][0] : 1'b0;
        er = !eb && !reset;
        cmp("z", z, ez);
        cmp("done", done, ed);
        cmp("busy", busy, eb);
        cmp("in_ready", in_ready, er);
      end
    end
  end

  // Sends one character; cycle 1 is the cycle after the accept edge.
  // Optionally pulses in_valid around cycle pulse_at while the character runs.
  task automatic run_char(input logic [4:0] c, input logic [2:0] l, input logic wg,
                          input int pulse_at, output int done_cyc, output int ones);
    done_cyc = -1;
    ones     = 0;
    @(posedge clk); #1;
    in_code = c; in_len = l; in_word_gap = wg; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (z) ones++;
      if (k == pulse_at - 1) in_valid = 1'b1;
      if (k == pulse_at) in_valid = 1'b0;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  initial begin
    int dc, on, ndone, rise1, rise2, dones;
    logic pz;
    reset = 1'b1; in_valid = 1'b0; in_code = '0; in_len = '0; in_word_gap = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    cmp("reset_ready", in_ready, 1'b0);
    cmp("reset_z", z, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    cmp("ready_after_reset", in_ready, 1'b1);

    // 'A'
    run_char(5'b00010, 3'd2, 1'b0, 0, dc, on);
    check_int("A_done_cycle", dc, 16);
    check_int("A_mark_cycles", on, 8);
    @(negedge clk);
    cmp("A_ready_c17", in_ready, 1'b1);

    // 'T' with word gap
    run_char(5'b00001, 3'd1, 1'b1, 0, dc, on);
    check_int("T_word_done_cycle", dc, 20);
    check_int("T_word_mark_cycles", on, 6);

    // gap only
    run_char(5'b10101, 3'd0, 1'b0, 0, dc, on);
    check_int("gap3_done_cycle", dc, 6);
    check_int("gap3_mark_cycles", on, 0);
    run_char(5'b00000, 3'd0, 1'b1, 0, dc, on);
    check_int("gap7_done_cycle", dc, 14);

    // clamp len=7 to 5 dashes, with an ignored in_valid pulse mid-character
    run_char(5'b11111, 3'd7, 1'b0, 10, dc, on);
    check_int("clamp_done_cycle", dc, 44);
    check_int("clamp_mark_cycles", on, 30);

    // back-to-back 'E' 'E' with in_valid held
    @(posedge clk); #1;
    in_code = 5'b00000; in_len = 3'd1; in_word_gap = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    pz = 1'b0; rise1 = -1; rise2 = -1; dones = 0; dc = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (z && !pz) begin
        if (rise1 < 0) rise1 = k;
        else if (rise2 < 0) rise2 = k;
      end
      pz = z;
      if (k == 10) in_valid = 1'b0;
      if (done) begin
        dones++;
        if (dones == 2) begin
          dc = k;
          break;
        end
      end
    end
    check_int("b2b_first_mark", rise1, 1);
    check_int("b2b_second_mark", rise2, 10);
    check_int("b2b_second_done", dc, 17);

    // reset in the middle of a dash
    @(posedge clk); #1;
    in_code = 5'b00001; in_len = 3'd1; in_word_gap = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ndone = 0;
    @(negedge clk);
    cmp("rst_mid_z_c1", z, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    if (done) ndone++;
    @(posedge clk); #1;
    @(negedge clk);
    cmp("rst_mid_z", z, 1'b0);
    cmp("rst_mid_busy", busy, 1'b0);
    cmp("rst_mid_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    cmp("rst_mid_ready_after", in_ready, 1'b1);
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_int("rst_mid_no_done", ndone, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
